// File: rtl/normalize_shift_left_seq_if.sv
// Handshake and payload bundle for the sequential left-shift normalizer.
// Producer drives the operand side and consumes the result side (master).
interface normalize_shift_left_seq_if #(
  parameter int unsigned MANT_W = 48,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic [EXP_W-1:0]  exp_in;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_out;
  logic [EXP_W-1:0]  exp_out;
  logic [CNT_W-1:0]  shift_cnt;
  logic              zero_flag;
  logic              underflow;

  modport master (
    output in_valid, mant_in, exp_in, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, shift_cnt, zero_flag, underflow
  );

  modport slave (
    input  in_valid, mant_in, exp_in, out_ready,
    output in_ready, out_valid, mant_out, exp_out, shift_cnt, zero_flag, underflow
  );
endinterface

// File: rtl/normalize_shift_left_seq.sv
// Sequential mantissa normalizer: one-bit left shift per cycle until the leading
// one reaches the MSB, the mantissa is zero, or the exponent floor (1) is reached.
module normalize_shift_left_seq #(
  parameter int unsigned MANT_W = 48,
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  normalize_shift_left_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [MANT_W-1:0] mant_out_q, mant_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic              zero_q, zero_d;
  logic              unf_q, unf_d;
  logic              in_ready_q, out_valid_q;

  // State, working operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      mant_out_q  <= '0;
      exp_out_q   <= '0;
      shift_cnt_q <= '0;
      zero_q      <= 1'b0;
      unf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      mant_out_q  <= mant_out_d;
      exp_out_q   <= exp_out_d;
      shift_cnt_q <= shift_cnt_d;
      zero_q      <= zero_d;
      unf_q       <= unf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Next-state and result capture; result registers only change on entry to DONE
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    mant_out_d  = mant_out_q;
    exp_out_d   = exp_out_q;
    shift_cnt_d = shift_cnt_q;
    zero_d      = zero_q;
    unf_d       = unf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mant_d  = bus.mant_in;
          exp_d   = bus.exp_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (mant_q == '0) begin
          state_d     = DONE;
          mant_out_d  = '0;
          exp_out_d   = '0;
          shift_cnt_d = '0;
          zero_d      = 1'b1;
          unf_d       = 1'b0;
        end else if (mant_q[MANT_W-1]) begin
          state_d     = DONE;
          mant_out_d  = mant_q;
          exp_out_d   = exp_q;
          shift_cnt_d = cnt_q;
          zero_d      = 1'b0;
          unf_d       = 1'b0;
        end else if (exp_q <= EXP_W'(1)) begin
          // Exponent floor: stop rather than decrement below 1 or wrap from 0
          state_d     = DONE;
          mant_out_d  = mant_q;
          exp_out_d   = exp_q;
          shift_cnt_d = cnt_q;
          zero_d      = 1'b0;
          unf_d       = 1'b1;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mant_out  = mant_out_q;
  assign bus.exp_out   = exp_out_q;
  assign bus.shift_cnt = shift_cnt_q;
  assign bus.zero_flag = zero_q;
  assign bus.underflow = unf_q;

endmodule

// File: doc/normalize_shift_left_seq.md
NORMALIZE_SHIFT_LEFT_SEQ -- requirements
Module: normalize_shift_left_seq

Interface
- REQ-001 Parameter MANT_W, default 48, mantissa/product width; bit MANT_W-1 is the normalized leading-one position.
- REQ-002 Parameter EXP_W, default 10, width of the biased working exponent (covers exponent-sum overflow range).
- REQ-003 Parameter CNT_W, default 6, shift-count width; SHALL satisfy 2^CNT_W > MANT_W-1.
- REQ-004 clk  input  1  single clock; all state updates on rising edge.
- REQ-005 rst  input  1  synchronous, active-high reset.
- REQ-006 in_valid  input  1  operand present on mant_in/exp_in.
- REQ-007 in_ready  output  1  block can accept an operand.
- REQ-008 mant_in  input  MANT_W  unnormalized mantissa.
- REQ-009 exp_in  input  EXP_W  biased exponent of mant_in, unsigned.
- REQ-010 out_valid  output  1  result present on the outputs below.
- REQ-011 out_ready  input  1  consumer accepts the result.
- REQ-012 mant_out  output  MANT_W  left-shifted mantissa.
- REQ-013 exp_out  output  EXP_W  adjusted exponent.
- REQ-014 shift_cnt  output  CNT_W  number of 1-bit left shifts applied.
- REQ-015 zero_flag  output  1  mant_in was zero.
- REQ-016 underflow  output  1  stopped on the exponent floor before normalization.

Function
- REQ-017 FSM states: IDLE, SHIFT, DONE; encoding is free.
- REQ-018 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge captures mant_in, exp_in, clears the count, clears the flags, and moves to SHIFT.
- REQ-019 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and no operand is captured.
- REQ-020 SHIFT, per edge, in priority order:
  - (a) working mantissa == 0 -> DONE with zero_flag=1, mant_out=0, exp_out=0, shift_cnt=0;
  - (b) mantissa[MANT_W-1]==1 -> DONE;
  - (c) exponent <= 1 -> DONE with underflow=1;
  - (d) otherwise mantissa <<= 1 (zero fill), exponent -= 1, count += 1, stay in SHIFT.
- REQ-021 Exactly one bit of shift per cycle; no multi-bit shifting or leading-zero-count shortcut.
- REQ-022 Latency: with N shifts required, out_valid SHALL rise after edge E0+N+1, where E0 is the accept edge. N=0 gives out_valid one cycle after accept. Maximum N is MANT_W-1.
- REQ-023 The exponent SHALL never decrement below 1 and SHALL never wrap. exp_in==0 with a nonzero unnormalized mantissa terminates at once with underflow=1, exp_out=0, shift_cnt=0.
- REQ-024 DONE: out_valid=1. mant_out, exp_out, shift_cnt, zero_flag and underflow SHALL hold stable until the edge where out_ready=1, which returns the FSM to IDLE.
- REQ-025 out_valid and in_ready SHALL never both be 1; the block holds at most one operand, with no pass-through and no overlap.
- REQ-026 In IDLE and SHIFT, the result outputs SHALL hold their last completed values. They are only guaranteed meaningful while out_valid=1.
- REQ-027 zero_flag and underflow SHALL never both be 1.

Reset
- REQ-028 rst=1 at an edge forces IDLE from any state, including mid-SHIFT and DONE; a pending operand or result is discarded.
- REQ-029 Values after reset: in_ready=1, out_valid=0, mant_out=0, exp_out=0, shift_cnt=0, zero_flag=0, underflow=0.
- REQ-030 in_valid asserted during a reset cycle SHALL NOT be captured.

Verification
- REQ-031 mant_in=0x800000000000, exp_in=200 -> out_valid one cycle after accept; mant_out=0x800000000000, exp_out=200, shift_cnt=0, flags 0.
- REQ-032 mant_in=0x000000000001, exp_in=100 -> 47 shifts; out_valid after E0+48; mant_out=0x800000000000, exp_out=53, shift_cnt=47.
- REQ-033 mant_in=0x000000000001, exp_in=10 -> 9 shifts; mant_out=0x000000000200, exp_out=1, shift_cnt=9, underflow=1.
- REQ-034 mant_in=0, exp_in=150 -> out_valid one cycle after accept; zero_flag=1, mant_out=0, exp_out=0, shift_cnt=0.
- REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new operand -> outputs unchanged, in_ready=0, new operand not captured. Then out_ready=1 -> IDLE, and the new operand is accepted the following edge.
- REQ-036 Reset mid-operation: assert rst at shift 20 of the REQ-032 case -> next cycle IDLE with all REQ-029 values. A subsequent operand completes normally.
